store_buffer_ctrl: RTL and testbench

Store buffer and data-cache request arbiter. It sits between the WB stage and the single data-cache request channel. Committed stores from WB are held in a small in-order FIFO and drained to the cache one at a time. Load requests from EXE are interleaved with the drain, with priority and address-conflict rules that keep memory ordering intact. There is one outstanding cache transaction at a time.

---
 rtl/store_buffer_ctrl_pkg.sv | 25 ++
 rtl/store_buffer_ctrl_sb_fifo.sv | 56 +++++
 rtl/store_buffer_ctrl.sv | 115 +++++++++++
 tb/tb_store_buffer_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_ctrl_pkg.sv
// store_buffer_ctrl_pkg: shared types and defaults for the store buffer and cache arbiter
package store_buffer_ctrl_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_ADDR,
        S_ST_DATA,
        S_LD_ADDR,
        S_LD_DATA
    } sb_state_t;

    // Entry widths follow the package defaults; the block's ADDR_W/DATA_W must match them.
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] wdata;
        logic [3:0]           wstrb;
        logic                 uncache;
        logic                 valid;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_ctrl_sb_fifo.sv
// sb_fifo: in-order committed-store storage with occupancy and per-entry word-address match
module sb_fifo
    import store_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  sb_entry_t              wr_entry,
    input  logic [SB_ADDR_W-1:2]   cmp_word,
    output sb_entry_t              head,
    output logic [PW:0]            count,
    output logic                   full,
    output logic [DEPTH-1:0]       hit
);

    sb_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;

    assign full    = count == (PW+1)'(DEPTH);
    assign do_push = push & ~full;
    assign head    = mem[rd_ptr];

    // pointer/occupancy bookkeeping; a push while full is dropped even if the head pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(pop);
        end
    end

    // word-address match of every live entry; the in-flight store is still the live head
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++)
            hit[i] = mem[i].valid & (mem[i].addr[SB_ADDR_W-1:2] == cmp_word);
    end

endmodule

// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: store buffer drain and load arbitration onto a single data-cache channel
module store_buffer_ctrl
    import store_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_push_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    input  logic [3:0]        st_wstrb_i,
    input  logic              st_uncache_i,
    output logic              st_full_o,
    output logic              sb_empty_o,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic              ld_uncache_i,
    output logic              ld_addr_ok_o,
    output logic              ld_data_ok_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    input  logic              excep_flush_i,
    output logic              cache_req_o,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    output logic [DATA_W-1:0] cache_wdata_o,
    output logic [3:0]        cache_wstrb_o,
    output logic              cache_uncache_o,
    input  logic              cache_addr_ok_i,
    input  logic              cache_data_ok_i,
    input  logic [DATA_W-1:0] cache_rdata_i
);

    localparam int PW = $clog2(DEPTH);

    sb_state_t         state;
    sb_state_t         state_nxt;
    sb_entry_t         wr_entry;
    sb_entry_t         head;
    logic [PW:0]       count;
    logic [DEPTH-1:0]  hit;
    logic              full;
    logic              pop;
    logic              cancel;
    logic              conflict;
    logic              st_issue;
    logic              ld_issue;

    assign wr_entry = '{addr: st_addr_i, wdata: st_wdata_i, wstrb: st_wstrb_i,
                        uncache: st_uncache_i, valid: 1'b1};
    assign pop      = (state == S_ST_DATA) & cache_data_ok_i;
    assign conflict = (|hit) | (ld_uncache_i & ~sb_empty_o);

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (st_push_i),
        .pop      (pop),
        .wr_entry (wr_entry),
        .cmp_word (ld_addr_i[ADDR_W-1:2]),
        .head     (head),
        .count    (count),
        .full     (full),
        .hit      (hit)
    );

    // channel state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // arbitration: a full buffer beats loads, a clean load beats a partial drain
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    state_nxt = full ? S_ST_ADDR :
                                   (ld_req_i & ~excep_flush_i & ~conflict) ? S_LD_ADDR :
                                   (count != '0) ? S_ST_ADDR : S_IDLE;
            S_ST_ADDR: state_nxt = cache_addr_ok_i ? S_ST_DATA : S_ST_ADDR;
            S_ST_DATA: state_nxt = cache_data_ok_i ? S_IDLE : S_ST_DATA;
            S_LD_ADDR: state_nxt = cache_addr_ok_i ? S_LD_DATA :
                                   excep_flush_i ? S_IDLE : S_LD_ADDR;
            S_LD_DATA: state_nxt = cache_data_ok_i ? S_IDLE : S_LD_DATA;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // a load flushed after acceptance still owns the channel until its data returns, but is not reported
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                                    cancel <= 1'b0;
        else if (state_nxt == S_IDLE)                                  cancel <= 1'b0;
        else if (excep_flush_i & ((state == S_LD_DATA) | ld_addr_ok_o)) cancel <= 1'b1;
    end

    // cache request and load handshake outputs
    always_comb begin
        st_issue        = (state == S_ST_ADDR) & head.valid;
        ld_issue        = state == S_LD_ADDR;
        cache_req_o     = st_issue | ld_issue;
        cache_we_o      = st_issue;
        cache_addr_o    = st_issue ? head.addr : ld_issue ? ld_addr_i : '0;
        cache_wdata_o   = st_issue ? head.wdata : '0;
        cache_wstrb_o   = st_issue ? head.wstrb : '0;
        cache_uncache_o = st_issue ? head.uncache : ld_issue & ld_uncache_i;
        ld_addr_ok_o    = ld_issue & cache_addr_ok_i;
        ld_data_ok_o    = (state == S_LD_DATA) & cache_data_ok_i & ~cancel;
        ld_rdata_o      = cache_rdata_i;
        st_full_o       = full;
        sb_empty_o      = (count == '0) & (state != S_ST_ADDR) & (state != S_ST_DATA);
    end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb_store_buffer_ctrl: random stimulus against a transaction-level store buffer model
module tb_store_buffer_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        st_push_i = 1'b0;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_wdata_i = '0;
    logic [3:0]  st_wstrb_i = '0;
    logic        st_uncache_i = 1'b0;
    logic        st_full_o;
    logic        sb_empty_o;
    logic        ld_req_i = 1'b0;
    logic [31:0] ld_addr_i = '0;
    logic        ld_uncache_i = 1'b0;
    logic        ld_addr_ok_o;
    logic        ld_data_ok_o;
    logic [31:0] ld_rdata_o;
    logic        excep_flush_i = 1'b0;
    logic        cache_req_o;
    logic        cache_we_o;
    logic [31:0] cache_addr_o;
    logic [31:0] cache_wdata_o;
    logic [3:0]  cache_wstrb_o;
    logic        cache_uncache_o;
    logic        cache_addr_ok_i = 1'b0;
    logic        cache_data_ok_i = 1'b0;
    logic [31:0] cache_rdata_i = '0;

    store_buffer_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .st_push_i       (st_push_i),
        .st_addr_i       (st_addr_i),
        .st_wdata_i      (st_wdata_i),
        .st_wstrb_i      (st_wstrb_i),
        .st_uncache_i    (st_uncache_i),
        .st_full_o       (st_full_o),
        .sb_empty_o      (sb_empty_o),
        .ld_req_i        (ld_req_i),
        .ld_addr_i       (ld_addr_i),
        .ld_uncache_i    (ld_uncache_i),
        .ld_addr_ok_o    (ld_addr_ok_o),
        .ld_data_ok_o    (ld_data_ok_o),
        .ld_rdata_o      (ld_rdata_o),
        .excep_flush_i   (excep_flush_i),
        .cache_req_o     (cache_req_o),
        .cache_we_o      (cache_we_o),
        .cache_addr_o    (cache_addr_o),
        .cache_wdata_o   (cache_wdata_o),
        .cache_wstrb_o   (cache_wstrb_o),
        .cache_uncache_o (cache_uncache_o),
        .cache_addr_ok_i (cache_addr_ok_i),
        .cache_data_ok_i (cache_data_ok_i),
        .cache_rdata_i   (cache_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        u;
    } st_t;

    // model: pending stores in program order plus the one transaction owning the channel
    st_t sq[$];
    int  owner;      // 0 free, 1 store, 2 load
    bit  granted;    // owner's request accepted, waiting for data_ok
    bit  cancelled;  // accepted load was flushed
    bit  ld_pend;
    bit  did_rst;
    int  n_checks;
    int  n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        return 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        sq.delete();
        owner     = 0;
        granted   = 0;
        cancelled = 0;
    endtask

    task automatic check_reset();
        check("rst_full", st_full_o, 0);
        check("rst_empty", sb_empty_o, 1);
        check("rst_req", cache_req_o, 0);
        check("rst_we", cache_we_o, 0);
        check("rst_addr", cache_addr_o, 0);
        check("rst_wdata", cache_wdata_o, 0);
        check("rst_wstrb", cache_wstrb_o, 0);
        check("rst_unc", cache_uncache_o, 0);
        check("rst_ld_addr_ok", ld_addr_ok_o, 0);
        check("rst_ld_data_ok", ld_data_ok_o, 0);
        check("rst_rdata", ld_rdata_o, cache_rdata_i);
    endtask

    task automatic check_outputs();
        bit st_req;
        bit ld_rq;
        st_req = owner == 1 && !granted;
        ld_rq  = owner == 2 && !granted;
        check("st_full", st_full_o, sq.size() == DEPTH);
        check("sb_empty", sb_empty_o, sq.size() == 0 && owner != 1);
        check("cache_req", cache_req_o, st_req || ld_rq);
        check("cache_we", cache_we_o, st_req);
        check("cache_addr", cache_addr_o, st_req ? sq[0].a : ld_rq ? ld_addr_i : 32'h0);
        check("cache_wdata", cache_wdata_o, st_req ? sq[0].d : 32'h0);
        check("cache_wstrb", cache_wstrb_o, st_req ? sq[0].s : 4'h0);
        check("cache_unc", cache_uncache_o, st_req ? sq[0].u : (ld_rq && ld_uncache_i));
        check("ld_addr_ok", ld_addr_ok_o, ld_rq && cache_addr_ok_i);
        check("ld_data_ok", ld_data_ok_o, owner == 2 && granted && cache_data_ok_i && !cancelled);
        check("ld_rdata", ld_rdata_o, cache_rdata_i);
    endtask

    // advance the model by one rising edge using the inputs held during the cycle
    task automatic model_step();
        bit full_now;
        bit conflict;
        bit ld_acc;
        full_now = sq.size() == DEPTH;
        conflict = ld_uncache_i && (sq.size() != 0 || owner == 1);
        ld_acc   = 0;
        foreach (sq[i]) if (sq[i].a[31:2] == ld_addr_i[31:2]) conflict = 1;
        if (owner == 0) begin
            granted = 0;
            if (full_now) owner = 1;
            else if (ld_req_i && !excep_flush_i && !conflict) begin
                owner     = 2;
                cancelled = 0;
            end else if (sq.size() != 0) owner = 1;
        end else if (owner == 1) begin
            if (!granted) granted = cache_addr_ok_i;
            else if (cache_data_ok_i) begin
                sq.delete(0);
                owner = 0;
            end
        end else begin
            if (!granted) begin
                if (cache_addr_ok_i) begin
                    granted   = 1;
                    cancelled = excep_flush_i;
                    ld_acc    = 1;
                end else if (excep_flush_i) owner = 0;
            end else if (cache_data_ok_i) owner = 0;
            else if (excep_flush_i) cancelled = 1;
        end
        if (st_push_i && !full_now) sq.push_back('{st_addr_i, st_wdata_i, st_wstrb_i, st_uncache_i});
        if (ld_req_i && (ld_acc || excep_flush_i)) ld_pend = 0;
    endtask

    task automatic cycle(input int p_push, input int p_ack, input int p_flush, input int p_ld, input bit rst_now);
        @(negedge clk);
        st_push_i    = $urandom_range(0, 99) < p_push;
        st_addr_i    = pick_addr();
        st_wdata_i   = $urandom;
        st_wstrb_i   = 4'($urandom_range(0, 15));
        st_uncache_i = $urandom_range(0, 7) == 0;
        if (!ld_pend && $urandom_range(0, 99) < p_ld) begin
            ld_pend      = 1;
            ld_addr_i    = pick_addr();
            ld_uncache_i = $urandom_range(0, 4) == 0;
        end
        ld_req_i        = ld_pend;
        excep_flush_i   = $urandom_range(0, 99) < p_flush;
        cache_addr_ok_i = $urandom_range(0, 99) < p_ack;
        cache_data_ok_i = owner != 0 && granted && $urandom_range(0, 99) < p_ack;
        cache_rdata_i   = cache_data_ok_i ? $urandom : 32'h0;
        #1;
        check_outputs();
        if (rst_now) begin
            #1 rst_n = 1'b0;
            #1 check_reset();
            model_reset();
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
        model_step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ld_pend  = 0;
        did_rst  = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #11 check_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) cycle(40, 100, 5, 25, 0);
        for (int i = 0; i < 1500; i++) begin
            if (!did_rst && i > 200 && owner == 1 && granted) begin
                did_rst = 1;
                cycle(60, 50, 10, 25, 1);
            end else cycle(60, 50, 10, 25, 0);
        end
        for (int i = 0; i < 1500; i++) cycle(30, 30, 20, 40, 0);
        for (int i = 0; i < 40; i++) cycle(0, 100, 0, 0, 0);
        #1;
        check("drained_empty", sb_empty_o, 1);
        check("drained_req", cache_req_o, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
